// File: rtl/nios2_control_ram_tester.sv
// nios2_control_ram_tester
//
// Purpose: fills a window of an on-chip RAM with an incrementing pattern
// P(i) = seed + i, reads the window back and counts mismatches. The RAM is
// an Avalon-MM slave with no waitrequest and a fixed read latency of one
// cycle, so a read issued in one cycle is checked at the end of the next.
//
// Ports:
//   clk, reset           single rising-edge clock, async active-high reset
//   start, abort         one-cycle pass request / terminate a running pass
//   base, length, seed   first word address, word count (0..2^ADDR_W), pattern seed
//   busy, done, aborted  pass active / one-cycle end pulse / last pass aborted
//   err_count            mismatches seen in the last pass
//   first_err_addr/data  address and read data of the first mismatch
//   address, byteenable, chipselect, write, writedata, clken, readdata
//                        Avalon-MM master towards the RAM slave
module nios2_control_ram_tester #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W:0]   cnt, next_cnt, cnt_inc;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] seed_q;

    logic              next_busy, next_done, next_cs, next_wr;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_wdata;
    logic              accept, abort_hit, issue_read;

    // Read pipeline: describes the read on the bus last cycle, whose data
    // arrives on readdata during this cycle.
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_exp;

    assign cnt_inc = cnt + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state and next-output logic. Every bus/status output is the
    // registered copy of the value computed here, so the bus shows index
    // cnt during the cycle the FSM is in WRITE or READ for that index.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_addr  = address;
        next_wdata = writedata;
        next_cs    = 1'b0;
        next_wr    = 1'b0;
        next_busy  = 1'b0;
        next_done  = 1'b0;
        accept     = 1'b0;
        abort_hit  = 1'b0;
        issue_read = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    next_cnt = '0;
                    if (length == '0) begin
                        next_state = ST_DONE;
                        next_done  = 1'b1;
                    end else begin
                        next_state = ST_WRITE;
                        next_addr  = base;
                        next_wdata = seed;
                        next_cs    = 1'b1;
                        next_wr    = 1'b1;
                        next_busy  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    next_state = ST_DONE;
                    next_done  = 1'b1;
                end else if (cnt_inc == len_q) begin
                    next_state = ST_READ;
                    next_cnt   = '0;
                    next_addr  = base_q;
                    next_cs    = 1'b1;
                    next_busy  = 1'b1;
                end else begin
                    next_cnt   = cnt_inc;
                    next_addr  = base_q + cnt_inc[ADDR_W-1:0];
                    next_wdata = seed_q + DATA_W'(cnt_inc);
                    next_cs    = 1'b1;
                    next_wr    = 1'b1;
                    next_busy  = 1'b1;
                end
            end
            ST_READ: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    next_state = ST_DONE;
                    next_done  = 1'b1;
                end else begin
                    issue_read = 1'b1;
                    next_busy  = 1'b1;
                    if (cnt_inc == len_q) begin
                        next_state = ST_DRAIN;
                    end else begin
                        next_cnt  = cnt_inc;
                        next_addr = base_q + cnt_inc[ADDR_W-1:0];
                        next_cs   = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                abort_hit  = abort;
                next_state = ST_DONE;
                next_done  = 1'b1;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered bus/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            clken      <= 1'b0;
            byteenable <= 4'h0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            busy       <= next_busy;
            done       <= next_done;
            chipselect <= next_cs;
            write      <= next_wr;
            address    <= next_addr;
            writedata  <= next_wdata;
            clken      <= 1'b1;
            byteenable <= 4'hF;
        end
    end

    // Pass parameters, read pipeline and result registers. A read issued
    // in the cycle abort is seen never enters the pipeline, so it is never
    // compared; results only change on an accepted start or a comparison.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q         <= '0;
            len_q          <= '0;
            seed_q         <= '0;
            pend_valid     <= 1'b0;
            pend_addr      <= '0;
            pend_exp       <= '0;
            aborted        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            pend_valid <= issue_read;
            pend_addr  <= address;
            pend_exp   <= seed_q + DATA_W'(cnt);
            if (accept) begin
                base_q         <= base;
                len_q          <= length;
                seed_q         <= seed;
                aborted        <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
            end else begin
                if (abort_hit) begin
                    aborted <= 1'b1;
                end
                if (pend_valid && (readdata != pend_exp)) begin
                    err_count <= err_count + {{ADDR_W{1'b0}}, 1'b1};
                    if (err_count == '0) begin
                        first_err_addr <= pend_addr;
                        first_err_data <= readdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nios2_control_ram_tester.sv
// tb_nios2_control_ram_tester
//
// Purpose: self-checking bench for nios2_control_ram_tester. A behavioural
// RAM with one cycle of read latency answers the DUT, optionally corrupting
// selected addresses. Table vectors cover complete passes; hand-written
// sequences cover length 0, abort, start/abort collisions and reset mid-pass.
module tb_nios2_control_ram_tester;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [9:0]  base;
    logic [10:0] length;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;
    logic [31:0] first_err_data;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        clken;
    logic [31:0] readdata;

    int n_compared = 0;
    int n_mismatch = 0;

    nios2_control_ram_tester #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base(base), .length(length), .seed(seed),
        .busy(busy), .done(done), .aborted(aborted), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .clken(clken), .readdata(readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: corrupt_mode 1 breaks addresses 5 and 7,
    // corrupt_mode 2 breaks addresses 4..7.
    logic [31:0] mem [0:1023];
    int          corrupt_mode = 0;

    function automatic logic [31:0] ramRead(input logic [9:0] a);
        logic bad;
        bad = ((corrupt_mode == 1) && (a == 10'd5 || a == 10'd7)) ||
              ((corrupt_mode == 2) && (a >= 10'd4) && (a <= 10'd7));
        if (!bad) return mem[a];
        if (a == 10'd5) return 32'hDEAD_BEEF;
        return 32'hBAD0_0000 | {22'd0, a};
    endfunction

    always @(posedge clk) begin
        if (chipselect && write) mem[address] <= writedata;
        if (chipselect && !write) readdata <= ramRead(address);
    end

    // Bus monitor, sampled mid-cycle.
    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } acc_t;

    acc_t acc_q[$];
    int   busy_cnt = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (chipselect) acc_q.push_back('{wr: write, addr: address, data: writedata});
        end
    end

    typedef struct {
        logic [9:0]  base;
        logic [10:0] len;
        logic [31:0] seed;
        int          corrupt;
        logic [10:0] exp_err;
        logic [9:0]  exp_fa;
        logic [31:0] exp_fd;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] b, input logic [10:0] l,
                                 input logic [31:0] s, input logic with_abort);
        @(negedge clk);
        base     = b;
        length   = l;
        seed     = s;
        start    = 1'b1;
        abort    = with_abort;
        busy_cnt = 0;
        done_cnt = 0;
        acc_q.delete();
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("done_seen", {63'd0, seen}, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    // Compares the recorded bus traffic with the write-then-read sequence
    // implied by base, length and seed.
    task automatic checkAccesses(input logic [9:0] b, input logic [10:0] l,
                                 input logic [31:0] s);
        int   bad;
        int   n;
        acc_t e;
        n   = int'(l);
        bad = 0;
        checkOutput("access_count", 64'(acc_q.size()), 64'(2 * n));
        for (int i = 0; i < 2 * n && i < acc_q.size(); i++) begin
            e.wr   = (i < n);
            e.addr = b + 10'(i % n);
            e.data = s + 32'(i % n);
            if (acc_q[i].wr !== e.wr || acc_q[i].addr !== e.addr ||
                (e.wr && acc_q[i].data !== e.data)) bad++;
        end
        checkOutput("access_sequence", 64'(bad), 64'd0);
    endtask

    initial begin
        int reads_seen;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base = '0;
        length = '0;
        seed = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        vecs[0] = '{10'd0,    11'd4,    32'h0000_0100, 0, 11'd0, 10'd0, 32'h0,         9};
        vecs[1] = '{10'd1022, 11'd4,    32'hA5A5_0000, 0, 11'd0, 10'd0, 32'h0,         9};
        vecs[2] = '{10'd4,    11'd8,    32'h0000_0000, 1, 11'd2, 10'd5, 32'hDEAD_BEEF, 17};
        vecs[3] = '{10'd1023, 11'd1,    32'hFFFF_FFFF, 0, 11'd0, 10'd0, 32'h0,         3};
        vecs[4] = '{10'd2,    11'd6,    32'h0000_0010, 2, 11'd4, 10'd4, 32'hBAD0_0004, 13};
        vecs[5] = '{10'd100,  11'd1024, 32'hFFFF_FFF0, 0, 11'd0, 10'd0, 32'h0,         2049};

        // Reset state
        #12;
        checkOutput("reset_status", {61'd0, busy, done, aborted}, 64'd0);
        checkOutput("reset_err_count", 64'(err_count), 64'd0);
        checkOutput("reset_first_err", {22'd0, first_err_addr, first_err_data}, 64'd0);
        checkOutput("reset_bus", {21'd0, chipselect, write, address, writedata}, 64'd0);
        checkOutput("reset_clken", 64'(clken), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("clken_after_reset", 64'(clken), 64'd1);
        checkOutput("byteenable", 64'(byteenable), 64'hF);

        // Table-driven complete passes
        for (int v = 0; v < 6; v++) begin
            corrupt_mode = vecs[v].corrupt;
            applyStimulus(vecs[v].base, vecs[v].len, vecs[v].seed, 1'b0);
            waitDone(2 * int'(vecs[v].len) + 20);
            $display("[TB] vector %0d base=%0d len=%0d", v, vecs[v].base, vecs[v].len);
            checkOutput("err_count", 64'(err_count), 64'(vecs[v].exp_err));
            checkOutput("first_err_addr", 64'(first_err_addr), 64'(vecs[v].exp_fa));
            checkOutput("first_err_data", 64'(first_err_data), 64'(vecs[v].exp_fd));
            checkOutput("aborted", 64'(aborted), 64'd0);
            checkOutput("busy_cycles", 64'(busy_cnt), 64'(vecs[v].exp_busy));
            checkOutput("done_pulses", 64'(done_cnt), 64'd1);
            checkAccesses(vecs[v].base, vecs[v].len, vecs[v].seed);
        end
        corrupt_mode = 0;

        // Length 0: done on the next cycle, no bus activity
        applyStimulus(10'd7, 11'd0, 32'h1234, 1'b0);
        checkOutput("len0_done_next", {62'd0, done, busy}, 64'd2);
        repeat (4) @(negedge clk);
        checkOutput("len0_busy_cycles", 64'(busy_cnt), 64'd0);
        checkOutput("len0_accesses", 64'(acc_q.size()), 64'd0);
        checkOutput("len0_done_pulses", 64'(done_cnt), 64'd1);

        // Abort on the 3rd READ cycle; reads of 4 and 5 are compared,
        // the in-flight read of 6 is not
        corrupt_mode = 2;
        applyStimulus(10'd4, 11'd8, 32'h0, 1'b0);
        reads_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (chipselect && !write) reads_seen++;
            if (reads_seen == 3) break;
            @(negedge clk);
        end
        checkOutput("abort_reached_read3", 64'(reads_seen), 64'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_cycle_bus", {62'd0, chipselect, busy}, 64'd0);
        checkOutput("abort_done", 64'(done), 64'd1);
        @(negedge clk);
        checkOutput("abort_aborted", 64'(aborted), 64'd1);
        checkOutput("abort_err_count", 64'(err_count), 64'd2);
        checkOutput("abort_first_addr", 64'(first_err_addr), 64'd4);
        checkOutput("abort_first_data", 64'(first_err_data), 64'hBAD0_0004);
        repeat (3) @(negedge clk);
        checkOutput("abort_access_count", 64'(acc_q.size()), 64'd11);
        checkOutput("abort_busy_cycles", 64'(busy_cnt), 64'd11);
        checkOutput("abort_done_pulses", 64'(done_cnt), 64'd1);
        corrupt_mode = 0;

        // Abort while idle is ignored and results hold
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        checkOutput("idle_abort_status", {61'd0, busy, done, aborted}, 64'd1);
        checkOutput("idle_abort_err_hold", 64'(err_count), 64'd2);

        // Start and abort together in IDLE: start wins
        applyStimulus(10'd50, 11'd2, 32'h5, 1'b1);
        waitDone(20);
        checkOutput("start_abort_aborted", 64'(aborted), 64'd0);
        checkOutput("start_abort_busy", 64'(busy_cnt), 64'd5);
        checkOutput("start_abort_err", 64'(err_count), 64'd0);
        checkAccesses(10'd50, 11'd2, 32'h5);

        // Start pulse while busy neither restarts nor extends the pass
        applyStimulus(10'd10, 11'd6, 32'h55, 1'b0);
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(30);
        repeat (5) @(negedge clk);
        checkOutput("busy_start_cycles", 64'(busy_cnt), 64'd13);
        checkOutput("busy_start_done", 64'(done_cnt), 64'd1);
        checkAccesses(10'd10, 11'd6, 32'h55);

        // Reset during WRITE discards the pass without done
        applyStimulus(10'd200, 11'd8, 32'h77, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_writing", {62'd0, chipselect, write}, 64'd3);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_status", {61'd0, busy, done, aborted}, 64'd0);
        checkOutput("midreset_bus", {21'd0, chipselect, write, address, writedata}, 64'd0);
        checkOutput("midreset_results", {11'd0, err_count, first_err_addr, first_err_data[31:0]} , 64'd0);
        checkOutput("midreset_clken", 64'(clken), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        repeat (20) @(negedge clk);
        checkOutput("postreset_done", 64'(done_cnt), 64'd0);
        checkOutput("postreset_busy", 64'(busy_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/nios2_control_ram_tester.md
NIOS2_CONTROL_RAM_TESTER -- requirements
Module: nios2_control_ram_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the RAM data width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle request to begin a fill/check pass.
REQ-006 SHALL have port abort, input, 1 bit, which terminates a pass in progress.
REQ-007 SHALL have port base, input, ADDR_W bits, the first word address.
REQ-008 SHALL have port length, input, ADDR_W+1 bits, the word count (0..1024).
REQ-009 SHALL have port seed, input, DATA_W bits, the pattern seed.
REQ-010 SHALL have port busy, output, 1 bit, high while a pass is active.
REQ-011 SHALL have port done, output, 1 bit, a one-cycle pulse when a pass ends.
REQ-012 SHALL have port aborted, output, 1 bit, set if the last pass ended by abort.
REQ-013 SHALL have port err_count, output, ADDR_W+1 bits, the mismatch count of the last pass.
REQ-014 SHALL have port first_err_addr, output, ADDR_W bits, the address of the first mismatch.
REQ-015 SHALL have port first_err_data, output, DATA_W bits, the data read at the first mismatch.
REQ-016 SHALL have Avalon-MM master outputs to the on-chip RAM slave: address (ADDR_W), byteenable (4), chipselect (1), write (1), writedata (DATA_W) and clken (1); it SHALL have input readdata (DATA_W).

Function
REQ-017 The master SHALL drive clken=1 and byteenable=4'hF at all times outside reset.
REQ-018 The slave has no waitrequest and a fixed read latency of 1: readdata for a read issued in cycle c SHALL be sampled at the end of cycle c+1.
REQ-019 The state machine SHALL have states IDLE, WRITE, READ, DRAIN and DONE.
REQ-020 In IDLE, start=1 SHALL latch base, length and seed, clear err_count, aborted, first_err_addr and first_err_data, and transition to WRITE. If the latched length is 0, it SHALL go to DONE instead.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 The word index i runs from 0 to L-1. The address for index i SHALL be (base+i) mod 2^ADDR_W, wrapping from 1023 to 0.
REQ-023 The pattern for index i SHALL be P(i) = (seed + i) mod 2^DATA_W.
REQ-024 WRITE SHALL issue one write per cycle with chipselect=1, write=1 and writedata=P(i), for L consecutive cycles, then go to READ.
REQ-025 READ SHALL issue one read per cycle with chipselect=1 and write=0, for L consecutive cycles, then go to DRAIN.
REQ-026 In DRAIN, chipselect SHALL be 0; this cycle compares the last read. The machine then goes to DONE.
REQ-027 The readdata sampled for index i SHALL be compared with P(i). On a mismatch, err_count SHALL increment. On the first mismatch of a pass, the block SHALL capture that index's address into first_err_addr and the readdata into first_err_data.
REQ-028 busy SHALL be high for exactly 2L+1 cycles (zero cycles if L=0).
REQ-029 DONE SHALL last one cycle: done=1 and busy=0, then return to IDLE.
REQ-030 Outside WRITE and READ, chipselect and write SHALL be 0.
REQ-031 abort=1 in WRITE, READ or DRAIN SHALL move the machine to DONE on the next edge and set aborted=1. No further accesses SHALL be issued, and a read still in flight SHALL NOT be compared.
REQ-032 abort=1 in IDLE or DONE SHALL be ignored.
REQ-033 If start and abort are both high in IDLE, start SHALL win.
REQ-034 All outputs SHALL be registered.
REQ-035 Result outputs SHALL hold their values until the next accepted start.

Reset
REQ-036 On reset=1, regardless of clk, the block SHALL go to IDLE and force all of these to 0: busy, done, aborted, err_count, first_err_addr, first_err_data, chipselect, write, address, writedata.
REQ-037 clken SHALL be 0 during reset and 1 from the first edge after reset deasserts.
REQ-038 Reset asserted mid-pass SHALL discard the pass without asserting done.

Verification
REQ-039 Scenario: base=0, length=4, seed=0x100, a model RAM with latency 1. Required: writes of 0x100..0x103 to addresses 0..3, then 4 reads; busy high for 9 cycles; done pulses once; err_count=0.
REQ-040 Scenario: base=1022, length=4. Required: accesses to addresses 1022, 1023, 0, 1, in that order, for both the writes and the reads.
REQ-041 Scenario: the model corrupts the read of address 5 to 0xDEADBEEF and of address 7, with base=4, length=8, seed=0. Required: err_count=2, first_err_addr=5, first_err_data=0xDEADBEEF.
REQ-042 Scenario: length=0 start. Required: done pulses on the next cycle, busy stays 0, and chipselect is never asserted.
REQ-043 Scenario: abort on the 3rd READ cycle of a length=8 pass. Required: chipselect is 0 from the next cycle; done and aborted are 1; err_count counts only the 2 compared reads.
REQ-044 Scenario: reset during WRITE, and a start pulse while busy. Required: after reset, all outputs are 0 and no done pulse occurs; the start pulse issued while busy does not restart or extend the pass.
